// File: rtl/dlx_pkg.sv
// Shared DLX opcode constants and small decode helpers used by the
// jump/branch unit.
package dlx_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQZ = 6'h04;
  localparam logic [OP_W-1:0] OP_BNEZ = 6'h05;
  localparam logic [OP_W-1:0] OP_RFE  = 6'h10;
  localparam logic [OP_W-1:0] OP_TRAP = 6'h11;
  localparam logic [OP_W-1:0] OP_JR   = 6'h12;
  localparam logic [OP_W-1:0] OP_JALR = 6'h13;

  // Linking opcodes write the return address into r31.
  function automatic logic is_link(input logic [OP_W-1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/jb_target_calc.sv
// Sign-extends the branch (16-bit) and jump (26-bit) offsets and adds them to
// pc_plus_four; additions wrap modulo 2^32.
module jb_target_calc
  import dlx_pkg::*;
(
  input  logic [0:31]       instruction,
  input  logic [DATA_W-1:0] pc_plus_four,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] jump_target
);

  logic [15:0] imm16;
  logic [25:0] off26;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext26(input logic [25:0] v);
    return {{(DATA_W-26){v[25]}}, v};
  endfunction

  // Instruction is big-endian numbered: bit 0 is the MSB of the opcode.
  assign opcode = instruction[0:5];
  assign off26  = instruction[6:31];
  assign imm16  = instruction[16:31];

  assign branch_target = pc_plus_four + $unsigned(sext16(imm16));
  assign jump_target   = pc_plus_four + $unsigned(sext26(off26));

endmodule

// File: rtl/jump_branch.sv
// DLX decode-stage jump/branch resolution: combinational next-PC selection and
// a single link register for JAL/JALR.
module jump_branch
  import dlx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:31]       instruction,
  input  logic [DATA_W-1:0] pc_plus_four,
  input  logic [DATA_W-1:0] rs1,
  output logic [DATA_W-1:0] outputPC,
  output logic              takeBranch,
  output logic [DATA_W-1:0] register31
);

  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] jump_target;
  logic              rs1_zero;

  jb_target_calc u_target (
    .instruction   (instruction),
    .pc_plus_four  (pc_plus_four),
    .opcode        (opcode),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  assign rs1_zero = (rs1 == '0);

  // Conditional branches present their target even when not taken.
  always_comb begin
    outputPC   = pc_plus_four;
    takeBranch = 1'b0;
    case (opcode)
      OP_J, OP_JAL: begin
        outputPC   = jump_target;
        takeBranch = 1'b1;
      end
      OP_BEQZ: begin
        outputPC   = branch_target;
        takeBranch = rs1_zero;
      end
      OP_BNEZ: begin
        outputPC   = branch_target;
        takeBranch = !rs1_zero;
      end
      OP_JR, OP_JALR: begin
        outputPC   = rs1;
        takeBranch = 1'b1;
      end
      default: begin
        outputPC   = pc_plus_four;
        takeBranch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      register31 <= '0;
    end else if (is_link(opcode)) begin
      register31 <= pc_plus_four;
    end
  end

endmodule

// File: tb/tb_jump_branch.sv
// Scoreboard bench for jump_branch: expected next-PC/take pairs are queued as
// stimulus is applied and popped when the combinational outputs settle.
module tb_jump_branch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic [31:0] pc_plus_four = 32'h0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] outputPC;
  logic        takeBranch;
  logic [31:0] register31;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        tb;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] r31_exp;

  jump_branch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .pc_plus_four (pc_plus_four),
    .rs1          (rs1),
    .outputPC     (outputPC),
    .takeBranch   (takeBranch),
    .register31   (register31)
  );

  always #5 clk = ~clk;

  // Independent reference for randomized traffic.
  function automatic void model(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] r, output logic [31:0] npc,
                                output logic t);
    logic [5:0]  op;
    logic [15:0] imm;
    logic [25:0] off;
    op  = ins[31:26];
    imm = ins[15:0];
    off = ins[25:0];
    npc = pc;
    t   = 1'b0;
    case (op)
      6'h02, 6'h03: begin npc = pc + {{6{off[25]}}, off}; t = 1'b1; end
      6'h04: begin npc = pc + {{16{imm[15]}}, imm}; t = (r == 0); end
      6'h05: begin npc = pc + {{16{imm[15]}}, imm}; t = (r != 0); end
      6'h12, 6'h13: begin npc = r; t = 1'b1; end
      default: begin npc = pc; t = 1'b0; end
    endcase
  endfunction

  task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r, input logic [31:0] exp_pc, input logic exp_tb);
    instruction  = ins;
    pc_plus_four = pc;
    rs1          = r;
    sb.push_back('{name, exp_pc, exp_tb});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (register31 !== 32'h0) begin
      bad++;
      $display("FAIL reset_r31: got=%h want=00000000", register31);
    end
    step();
    rst_n = 1'b1;
    r31_exp = 32'h0;
  endtask

  task automatic test_beqz();
    apply("beqz_taken", 32'h10000010, 32'h100, 32'h0, 32'h110, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    apply("beqz_not_taken", 32'h10000010, 32'h100, 32'h7, 32'h110, 1'b0);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
  endtask

  task automatic test_bnez();
    apply("bnez_back_taken", 32'h1400FFFC, 32'h200, 32'h5, 32'h1FC, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    apply("bnez_not_taken", 32'h1400FFFC, 32'h200, 32'h0, 32'h1FC, 1'b0);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
  endtask

  task automatic test_jump();
    apply("j_negative", 32'h0BFFFFF8, 32'h1000, 32'hDEAD, 32'hFF8, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    apply("j_wrap", 32'h08000020, 32'hFFFFFFF0, 32'h0, 32'h00000010, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    step();
    total++;
    if (register31 !== r31_exp) begin
      bad++;
      $display("FAIL j_no_link: got r31=%h want=%h", register31, r31_exp);
    end
  endtask

  task automatic test_jal();
    apply("jal", 32'h0C000040, 32'h2000, 32'h0, 32'h2040, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    step();
    r31_exp = 32'h2000;
    total++;
    if (register31 !== r31_exp) begin
      bad++;
      $display("FAIL jal_link: got r31=%h want=%h", register31, r31_exp);
    end
  endtask

  task automatic test_jalr_add();
    apply("jalr", 32'h4C000000, 32'h2004, 32'h3000, 32'h3000, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    step();
    r31_exp = 32'h2004;
    total++;
    if (register31 !== r31_exp) begin
      bad++;
      $display("FAIL jalr_link: got r31=%h want=%h", register31, r31_exp);
    end
    apply("add", 32'h00221820, 32'h2008, 32'h3000, 32'h2008, 1'b0);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    step();
    total++;
    if (register31 !== r31_exp) begin
      bad++;
      $display("FAIL add_hold_r31: got r31=%h want=%h", register31, r31_exp);
    end
  endtask

  task automatic test_other_ops();
    logic [31:0] ops [4] = '{32'h44000000, 32'h40000000, 32'h8C410004, 32'hAC410008};
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("other_op_%0d", i), ops[i], 32'h4000 + 32'(i * 4), 32'h0, 32'h4000 + 32'(i * 4), 1'b0);
      #1;
      e = sb.pop_front();
      total++;
      if (outputPC !== e.pc || takeBranch !== e.tb) begin
        bad++;
        $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
      end
    end
  endtask

  task automatic test_mid_cycle_change();
    step();
    apply("mid_add", 32'h00000020, 32'h500, 32'h0, 32'h500, 1'b0);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    #1;
    apply("mid_jr", 32'h48000000, 32'h500, 32'h1234, 32'h1234, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
  endtask

  task automatic test_reset_mid();
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (register31 !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_r31: got=%h want=00000000", register31);
    end
    apply("jal_during_reset", 32'h0C000010, 32'h6000, 32'h0, 32'h6010, 1'b1);
    #1;
    e = sb.pop_front();
    total++;
    if (outputPC !== e.pc || takeBranch !== e.tb) begin
      bad++;
      $display("FAIL %s: got pc=%h tb=%b want pc=%h tb=%b", e.name, outputPC, takeBranch, e.pc, e.tb);
    end
    step();
    total++;
    if (register31 !== 32'h0) begin
      bad++;
      $display("FAIL reset_over_jal: got r31=%h want=00000000", register31);
    end
    rst_n = 1'b1;
    step();
    r31_exp = 32'h6000;
    total++;
    if (register31 !== r31_exp) begin
      bad++;
      $display("FAIL link_after_reset: got r31=%h want=%h", register31, r31_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op_list [10] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h12, 6'h13, 6'h10, 6'h11, 6'h00, 6'h23};
    logic [31:0] ins, pc, r, npc;
    logic        t;
    for (int i = 0; i < 40; i++) begin
      ins = {op_list[$urandom_range(0, 9)], 26'($urandom)};
      pc  = $urandom;
      r   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      model(ins, pc, r, npc, t);
      apply($sformatf("b2b_%0d", i), ins, pc, r, npc, t);
      #1;
      e = sb.pop_front();
      total++;
      if (outputPC !== e.pc || takeBranch !== e.tb) begin
        bad++;
        $display("FAIL %s: ins=%h got pc=%h tb=%b want pc=%h tb=%b", e.name, ins, outputPC, takeBranch, e.pc, e.tb);
      end
      step();
      if (ins[31:26] == 6'h03 || ins[31:26] == 6'h13) r31_exp = pc;
      total++;
      if (register31 !== r31_exp) begin
        bad++;
        $display("FAIL b2b_r31_%0d: got=%h want=%h", i, register31, r31_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beqz();
    test_bnez();
    test_jump();
    test_jal();
    test_jalr_add();
    test_other_ops();
    test_mid_cycle_change();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
